// File: rtl/wb_stage_pkg.sv
// Shared constants and types for the register-file write-back stage.
package wb_stage_pkg;

    localparam int DATABUS   = 16;
    localparam int REG_IDX_W = 3;
    localparam int NREG      = 1 << REG_IDX_W;

    localparam logic REGWE_WRITE = 1'b1;
    localparam logic REGWE_HOLD  = 1'b0;

    // Which producer owns the write port in a given cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_FIFO = 2'd2,
        SRC_ALU  = 2'd3
    } wb_src_e;

endpackage

// File: rtl/wb_stage_if.sv
// Bus bundle between the execute/memory/decode side and the write-back stage.
interface wb_stage_if #(
    parameter int DATA_W = wb_stage_pkg::DATABUS,
    parameter int ADDR_W = wb_stage_pkg::REG_IDX_W,
    parameter int NREG   = wb_stage_pkg::NREG
);
    import wb_stage_pkg::*;

    logic              flush;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              ld_issue;
    logic [ADDR_W-1:0] ld_addr;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [ADDR_W-1:0] dec_rd;
    logic [ADDR_W-1:0] dec_rs;
    logic              hazard;
    logic [NREG-1:0]   busy;
    logic [ADDR_W-1:0] WB_addr;
    logic [DATA_W-1:0] WB_data;
    logic              RegWe;

    modport slave (
        input  flush, alu_valid, alu_addr, alu_data, ld_issue, ld_addr,
               mem_valid, mem_addr, mem_data, dec_rd, dec_rs,
        output alu_ready, hazard, busy, WB_addr, WB_data, RegWe
    );

    modport master (
        output flush, alu_valid, alu_addr, alu_data, ld_issue, ld_addr,
               mem_valid, mem_addr, mem_data, dec_rd, dec_rs,
        input  alu_ready, hazard, busy, WB_addr, WB_data, RegWe
    );

endinterface

// File: rtl/wb_fifo.sv
// Small in-order FIFO with flush, pointer-plus-wrap-bit full/empty and per-slot taps.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 19
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            pop_data,
    output logic                        full,
    output logic                        empty,
    output logic [DEPTH-1:0]            tap_valid,
    output logic [DEPTH-1:0][WIDTH-1:0] tap_entry
);
    import wb_stage_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign count    = wr_ptr_q - rd_ptr_q;
    assign pop_data = mem_q[rd_ptr_q[PTR_W-1:0]];

    // A push at full is only legal when the head leaves on the same edge.
    assign wr_en = push && !flush && (!full || pop);
    assign rd_en = pop && !flush && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end

    // A slot is live when its distance from the read pointer is below the fill count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
            logic [PTR_W-1:0] slot_off;
            assign slot_off      = PTR_W'(gi) - rd_ptr_q[PTR_W-1:0];
            assign tap_valid[gi] = ({1'b0, slot_off} < count);
            assign tap_entry[gi] = mem_q[gi];
        end
    endgenerate

endmodule

// File: rtl/wb_stage.sv
// Register-file write port arbiter: load returns, buffered ALU results, direct ALU results,
// plus a per-register scoreboard of outstanding loads for decode hazard detection.
module wb_stage #(
    parameter int DATA_W     = wb_stage_pkg::DATABUS,
    parameter int ADDR_W     = wb_stage_pkg::REG_IDX_W,
    parameter int NREG       = wb_stage_pkg::NREG,
    parameter int FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_stage_if.slave  bus
);
    import wb_stage_pkg::*;

    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic                             fifo_full;
    logic                             fifo_empty;
    logic                             fifo_push;
    logic                             fifo_pop;
    logic [ENTRY_W-1:0]               fifo_head;
    logic [FIFO_DEPTH-1:0]            tap_valid;
    logic [FIFO_DEPTH-1:0][ENTRY_W-1:0] tap_entry;
    logic [FIFO_DEPTH-1:0]            tap_hit;

    wb_src_e           src;
    logic              alu_acc;

    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              regwe_q,   regwe_d;
    logic [NREG-1:0]   busy_q,    busy_d;

    // Ready is pessimistic at full even though a same-cycle pop would make room.
    assign bus.alu_ready = !fifo_full;
    assign alu_acc       = bus.alu_valid && !fifo_full && !bus.flush;

    always_comb begin
        src = SRC_NONE;
        if (bus.mem_valid) begin
            src = SRC_MEM;
        end else if (!fifo_empty && !bus.flush) begin
            src = SRC_FIFO;
        end else if (alu_acc && fifo_empty) begin
            src = SRC_ALU;
        end
    end

    assign fifo_pop  = (src == SRC_FIFO);
    assign fifo_push = alu_acc && (src != SRC_ALU);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .push      (fifo_push),
        .push_data ({bus.alu_addr, bus.alu_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .tap_valid (tap_valid),
        .tap_entry (tap_entry)
    );

    always_comb begin
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        regwe_d   = REGWE_HOLD;
        unique case (src)
            SRC_MEM: begin
                wb_addr_d = bus.mem_addr;
                wb_data_d = bus.mem_data;
                regwe_d   = REGWE_WRITE;
            end
            SRC_FIFO: begin
                {wb_addr_d, wb_data_d} = fifo_head;
                regwe_d                = REGWE_WRITE;
            end
            SRC_ALU: begin
                wb_addr_d = bus.alu_addr;
                wb_data_d = bus.alu_data;
                regwe_d   = REGWE_WRITE;
            end
            default: ;
        endcase
    end

    // Clear before set so a reissue to the returning register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (bus.mem_valid) busy_d[bus.mem_addr] = 1'b0;
        if (bus.ld_issue)  busy_d[bus.ld_addr]  = 1'b1;
    end

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_hit
            logic [ADDR_W-1:0] tap_addr;
            assign tap_addr    = tap_entry[gi][ENTRY_W-1 -: ADDR_W];
            assign tap_hit[gi] = tap_valid[gi] &&
                                 ((tap_addr == bus.dec_rs) || (tap_addr == bus.dec_rd));
        end
    endgenerate

    assign bus.hazard = busy_q[bus.dec_rs] | busy_q[bus.dec_rd] | (|tap_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_addr_q <= '0;
            wb_data_q <= '0;
            regwe_q   <= REGWE_HOLD;
            busy_q    <= '0;
        end else begin
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            regwe_q   <= regwe_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.WB_addr = wb_addr_q;
    assign bus.WB_data = wb_data_q;
    assign bus.RegWe   = regwe_q;
    assign bus.busy    = busy_q;

endmodule
